// File: rtl/spi_peripheral.sv
// spi_peripheral
//   SPI target (peripheral) that supports all four CPOL/CPHA modes and
//   frames of up to MAX_BYTES bytes. The controller's CS_n, PCLK and COPI
//   are asynchronous to clk. Each of them passes through a synchronizer,
//   and PCLK is oversampled by clk (PCLK must run at clk/8 or slower).
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   CPOL, CPHA        SPI mode, latched when a frame starts
//   CS_n, PCLK, COPI  SPI bus from the controller
//   TxBuffer          reply bytes; [MAX_BYTES-1] is sent first, MSB first
//   CIPO, CIPO_OE     reply data and its output enable (active frame only)
//   RxBuffer          received bytes; [0] is the most recent complete byte
//   BYTE_DONE         one-clk pulse per completed received byte
//   FRAME_DONE        one-clk pulse when the frame ends
//   BYTE_COUNT        completed bytes in this/last frame, saturating
//   BUSY              high while a frame is active
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BYTES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CPOL,
  input  logic                       CPHA,
  input  logic                       CS_n,
  input  logic                       PCLK,
  input  logic                       COPI,
  input  logic [MAX_BYTES-1:0][7:0]  TxBuffer,
  output logic                       CIPO,
  output logic                       CIPO_OE,
  output logic [MAX_BYTES-1:0][7:0]  RxBuffer,
  output logic                       BYTE_DONE,
  output logic                       FRAME_DONE,
  output logic [2:0]                 BYTE_COUNT,
  output logic                       BUSY
);

  localparam int TXW = MAX_BYTES * 8;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]      pclk_sync_q, pclk_sync_d;
  logic [SYNC_STAGES-1:0]      copi_sync_q, copi_sync_d;
  logic                        cs_prev_q, cs_prev_d;
  logic                        pclk_prev_q, pclk_prev_d;
  logic [SYNC_STAGES:0]        prime_q, prime_d;
  logic                        armed_q, armed_d;
  logic                        cpol_q, cpol_d;
  logic                        cpha_q, cpha_d;
  logic [TXW-1:0]              tx_shift_q, tx_shift_d;
  logic [7:0]                  rx_shift_q, rx_shift_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic                        byte_pend_q, byte_pend_d;
  logic [MAX_BYTES-1:0][7:0]   rx_buf_q, rx_buf_d;
  logic [2:0]                  byte_cnt_q, byte_cnt_d;
  logic                        cipo_q, cipo_d;
  logic                        cipo_oe_q, cipo_oe_d;
  logic                        busy_q, busy_d;
  logic                        byte_done_q, byte_done_d;
  logic                        frame_done_q, frame_done_d;

  logic [TXW-1:0] tx_load;
  logic           cs_s, pclk_s, copi_s;
  logic           cs_fall, cs_rise, pclk_chg, lead_edge, trail_edge;
  logic           sample_edge, shift_edge;

  assign tx_load = TxBuffer;
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign pclk_s  = pclk_sync_q[SYNC_STAGES-1];
  assign copi_s  = copi_sync_q[SYNC_STAGES-1];

  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign pclk_chg = pclk_prev_q ^ pclk_s;
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = pclk_chg & (pclk_prev_q == cpol_q);
  assign trail_edge  = pclk_chg & (pclk_prev_q != cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_comb begin
    state_d      = state_q;
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], CS_n};
    pclk_sync_d  = {pclk_sync_q[SYNC_STAGES-2:0], PCLK};
    copi_sync_d  = {copi_sync_q[SYNC_STAGES-2:0], COPI};
    cs_prev_d    = cs_s;
    pclk_prev_d  = pclk_s;
    // prime_q fills with ones after reset; once full, cs_s and cs_prev_q
    // hold real pin samples instead of reset values. A frame may start only
    // after CS_n has really been seen high, so a CS_n that was already low
    // across reset never opens a partial frame.
    prime_d      = {prime_q[SYNC_STAGES-1:0], 1'b1};
    armed_d      = armed_q | (prime_q[SYNC_STAGES] & cs_s & cs_prev_q);
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_pend_d  = byte_pend_q;
    rx_buf_d     = rx_buf_q;
    byte_cnt_d   = byte_cnt_q;
    cipo_d       = cipo_q;
    byte_done_d  = 1'b0;

    // A byte finished on the previous clk: commit it to the buffer.
    if (byte_pend_q) begin
      for (int i = MAX_BYTES - 1; i >= 1; i--) begin
        rx_buf_d[i] = rx_buf_q[i-1];
      end
      rx_buf_d[0] = rx_shift_q;
      byte_done_d = 1'b1;
      byte_pend_d = 1'b0;
      if (byte_cnt_q < 3'(MAX_BYTES)) begin
        byte_cnt_d = byte_cnt_q + 3'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        cipo_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d     = ACTIVE;
          cpol_d      = CPOL;
          cpha_d      = CPHA;
          bit_cnt_d   = 3'd0;
          byte_cnt_d  = 3'd0;
          byte_pend_d = 1'b0;
          rx_shift_d  = 8'd0;
          if (CPHA) begin
            // The first bit goes out on the first leading edge.
            tx_shift_d = tx_load;
          end else begin
            // The first bit must be valid before the first sampling edge.
            cipo_d     = tx_load[TXW-1];
            tx_shift_d = {tx_load[TXW-2:0], 1'b0};
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Ending the frame wins over a PCLK edge in the same cycle.
          // Partial receive bits are dropped.
          state_d = DONE;
          cipo_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], copi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_pend_d = 1'b1;
            end
          end
          // Zeros shift in behind the reply, so CIPO is 0 once the buffer
          // has been sent.
          if (shift_edge) begin
            cipo_d     = tx_shift_q[TXW-1];
            tx_shift_d = {tx_shift_q[TXW-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cipo_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cipo_d  = 1'b0;
      end
    endcase

    cipo_oe_d    = (state_d == ACTIVE);
    busy_d       = (state_d == ACTIVE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cs_sync_q    <= '1;
      pclk_sync_q  <= '0;
      copi_sync_q  <= '0;
      cs_prev_q    <= 1'b1;
      pclk_prev_q  <= 1'b0;
      prime_q      <= '0;
      armed_q      <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      byte_pend_q  <= 1'b0;
      rx_buf_q     <= '0;
      byte_cnt_q   <= '0;
      cipo_q       <= 1'b0;
      cipo_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_sync_q    <= cs_sync_d;
      pclk_sync_q  <= pclk_sync_d;
      copi_sync_q  <= copi_sync_d;
      cs_prev_q    <= cs_prev_d;
      pclk_prev_q  <= pclk_prev_d;
      prime_q      <= prime_d;
      armed_q      <= armed_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_pend_q  <= byte_pend_d;
      rx_buf_q     <= rx_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      cipo_q       <= cipo_d;
      cipo_oe_q    <= cipo_oe_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign CIPO       = cipo_q;
  assign CIPO_OE    = cipo_oe_q;
  assign RxBuffer   = rx_buf_q;
  assign BYTE_DONE  = byte_done_q;
  assign FRAME_DONE = frame_done_q;
  assign BYTE_COUNT = byte_cnt_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral
//   Directed bench for spi_peripheral. A controller model drives CS_n, PCLK
//   and COPI, and captures CIPO just before each sampling edge. Pulse
//   outputs are counted on the falling clk edge.
module tb_spi_peripheral;

  localparam int H = 8;  // PCLK half period in clk cycles

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             CPOL = 1'b0;
  logic             CPHA = 1'b0;
  logic             CS_n = 1'b1;
  logic             PCLK = 1'b0;
  logic             COPI = 1'b0;
  logic [3:0][7:0]  TxBuffer = 32'hDEADCE11;
  logic             CIPO;
  logic             CIPO_OE;
  logic [3:0][7:0]  RxBuffer;
  logic             BYTE_DONE;
  logic             FRAME_DONE;
  logic [2:0]       BYTE_COUNT;
  logic             BUSY;

  int vectors     = 0;
  int miscompares = 0;
  int bd_cnt      = 0;
  int fd_cnt      = 0;
  int busy_cnt    = 0;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_BYTES(4)) dut (
    .clk(clk), .rst(rst), .CPOL(CPOL), .CPHA(CPHA), .CS_n(CS_n),
    .PCLK(PCLK), .COPI(COPI), .TxBuffer(TxBuffer), .CIPO(CIPO),
    .CIPO_OE(CIPO_OE), .RxBuffer(RxBuffer), .BYTE_DONE(BYTE_DONE),
    .FRAME_DONE(FRAME_DONE), .BYTE_COUNT(BYTE_COUNT), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (BYTE_DONE === 1'b1) bd_cnt++;
    if (FRAME_DONE === 1'b1) fd_cnt++;
    if (BUSY === 1'b1) busy_cnt++;
  end

  // One complete frame. Bit k of the frame is copi_word[nbits-1-k].
  // cipo_got collects the CIPO bits the controller sampled, oldest first.
  task automatic run_frame(input logic m_cpol, input logic m_cpha,
                           input int nbits, input logic [39:0] copi_word,
                           input bit toggle_cpol,
                           output logic [39:0] cipo_got,
                           output logic busy_mid);
    cipo_got = '0;
    CPOL = m_cpol;
    CPHA = m_cpha;
    PCLK = m_cpol;
    COPI = 1'b0;
    repeat (8) @(negedge clk);
    CS_n = 1'b0;
    repeat (8) @(negedge clk);
    busy_mid = BUSY;
    for (int k = 0; k < nbits; k++) begin
      if (!m_cpha) begin
        COPI = copi_word[nbits-1-k];
        repeat (H) @(negedge clk);
        cipo_got = {cipo_got[38:0], CIPO};
        PCLK = ~m_cpol;
        repeat (H) @(negedge clk);
        PCLK = m_cpol;
      end else begin
        PCLK = ~m_cpol;
        COPI = copi_word[nbits-1-k];
        repeat (H) @(negedge clk);
        cipo_got = {cipo_got[38:0], CIPO};
        PCLK = m_cpol;
        repeat (H) @(negedge clk);
      end
      if (toggle_cpol && k == 3) CPOL = ~CPOL;
    end
    repeat (H) @(negedge clk);
    CS_n = 1'b1;
    COPI = 1'b0;
    repeat (12) @(negedge clk);
    CPOL = m_cpol;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({CIPO, CIPO_OE, BUSY, BYTE_DONE, FRAME_DONE} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000",
               {CIPO, CIPO_OE, BUSY, BYTE_DONE, FRAME_DONE});
    end
    vectors++;
    if (RxBuffer !== 32'h0 || BYTE_COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_buf: got rx=%h cnt=%0d want 0/0", RxBuffer, BYTE_COUNT);
    end
    rst = 1'b0;
    $display("reset: rx=%h cnt=%0d", RxBuffer, BYTE_COUNT);
  endtask

  task automatic test_single_byte();
    logic [39:0] got;
    logic        bm;
    int          bd0, fd0;
    bd0 = bd_cnt; fd0 = fd_cnt;
    run_frame(1'b0, 1'b0, 8, 40'hA5, 1'b0, got, bm);
    $display("single: cipo=%h rx=%h cnt=%0d", got[7:0], RxBuffer, BYTE_COUNT);
    vectors++;
    if (got[7:0] !== 8'hDE) begin
      miscompares++; $display("FAIL single_cipo: got %h want de", got[7:0]);
    end
    vectors++;
    if (RxBuffer !== 32'h000000A5) begin
      miscompares++; $display("FAIL single_rx: got %h want 000000a5", RxBuffer);
    end
    vectors++;
    if (BYTE_COUNT !== 3'd1) begin
      miscompares++; $display("FAIL single_count: got %0d want 1", BYTE_COUNT);
    end
    vectors++;
    if (bd_cnt - bd0 != 1 || fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL single_pulses: got bd=%0d fd=%0d want 1/1", bd_cnt - bd0, fd_cnt - fd0);
    end
    vectors++;
    if (bm !== 1'b1 || BUSY !== 1'b0 || CIPO_OE !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy: got mid=%b end=%b oe=%b want 1/0/0", bm, BUSY, CIPO_OE);
    end
  endtask

  task automatic test_modes();
    logic [39:0] got;
    logic        bm;
    int          bd0;
    for (int m = 0; m < 4; m++) begin
      bd0 = bd_cnt;
      run_frame(m[1], m[0], 32, 40'h12345678, 1'b0, got, bm);
      $display("mode%0d: cipo=%h rx=%h bd=%0d", m, got[31:0], RxBuffer, bd_cnt - bd0);
      vectors++;
      if (got[31:0] !== 32'hDEADCE11) begin
        miscompares++; $display("FAIL mode%0d_cipo: got %h want deadce11", m, got[31:0]);
      end
      vectors++;
      if (RxBuffer !== 32'h12345678) begin
        miscompares++; $display("FAIL mode%0d_rx: got %h want 12345678", m, RxBuffer);
      end
      vectors++;
      if (bd_cnt - bd0 != 4) begin
        miscompares++; $display("FAIL mode%0d_bd: got %0d want 4", m, bd_cnt - bd0);
      end
    end
  endtask

  task automatic test_overflow();
    logic [39:0] got;
    logic        bm;
    int          bd0;
    bd0 = bd_cnt;
    run_frame(1'b0, 1'b0, 40, 40'h0102030405, 1'b0, got, bm);
    $display("overflow: cipo=%h rx=%h cnt=%0d", got, RxBuffer, BYTE_COUNT);
    vectors++;
    if (got !== 40'hDEADCE1100) begin
      miscompares++; $display("FAIL ovf_cipo: got %h want deadce1100", got);
    end
    vectors++;
    if (RxBuffer !== 32'h02030405) begin
      miscompares++; $display("FAIL ovf_rx: got %h want 02030405", RxBuffer);
    end
    vectors++;
    if (BYTE_COUNT !== 3'd4 || bd_cnt - bd0 != 5) begin
      miscompares++;
      $display("FAIL ovf_count: got cnt=%0d bd=%0d want 4/5", BYTE_COUNT, bd_cnt - bd0);
    end
  endtask

  task automatic test_abort();
    logic [39:0] got;
    logic        bm;
    int          bd0, fd0;
    bd0 = bd_cnt; fd0 = fd_cnt;
    run_frame(1'b0, 1'b0, 11, {29'd0, 8'h3C, 3'b101}, 1'b0, got, bm);
    $display("abort: rx=%h cnt=%0d bd=%0d fd=%0d", RxBuffer, BYTE_COUNT, bd_cnt - bd0, fd_cnt - fd0);
    vectors++;
    if (RxBuffer !== 32'h0304053C) begin
      miscompares++; $display("FAIL abort_rx: got %h want 0304053c", RxBuffer);
    end
    vectors++;
    if (BYTE_COUNT !== 3'd1) begin
      miscompares++; $display("FAIL abort_count: got %0d want 1", BYTE_COUNT);
    end
    vectors++;
    if (bd_cnt - bd0 != 1 || fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL abort_pulses: got bd=%0d fd=%0d want 1/1", bd_cnt - bd0, fd_cnt - fd0);
    end
  endtask

  task automatic test_cpol_change();
    logic [39:0] got;
    logic        bm;
    logic [7:0]  ref_rx;
    run_frame(1'b0, 1'b1, 8, 40'hC3, 1'b0, got, bm);
    ref_rx = RxBuffer[0];
    vectors++;
    if (ref_rx !== 8'hC3) begin
      miscompares++; $display("FAIL cpol_ref_rx: got %h want c3", ref_rx);
    end
    run_frame(1'b0, 1'b1, 8, 40'hC3, 1'b1, got, bm);
    $display("cpol_toggle: rx0=%h cipo=%h", RxBuffer[0], got[7:0]);
    vectors++;
    if (RxBuffer[0] !== 8'hC3 || got[7:0] !== 8'hDE) begin
      miscompares++;
      $display("FAIL cpol_toggle: got rx=%h cipo=%h want c3/de", RxBuffer[0], got[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] g1, g2;
    logic        bm;
    int          fd0;
    fd0 = fd_cnt;
    TxBuffer = 32'hA1B2C3D4;
    run_frame(1'b1, 1'b0, 8, 40'h11, 1'b0, g1, bm);
    run_frame(1'b1, 1'b0, 8, 40'h22, 1'b0, g2, bm);
    $display("b2b: cipo=%h,%h rx=%h fd=%0d", g1[7:0], g2[7:0], RxBuffer, fd_cnt - fd0);
    vectors++;
    if (RxBuffer[1] !== 8'h11 || RxBuffer[0] !== 8'h22) begin
      miscompares++;
      $display("FAIL b2b_rx: got %h%h want 1122", RxBuffer[1], RxBuffer[0]);
    end
    vectors++;
    if (g1[7:0] !== 8'hA1 || g2[7:0] !== 8'hA1 || fd_cnt - fd0 != 2) begin
      miscompares++;
      $display("FAIL b2b_cipo: got %h,%h fd=%0d want a1,a1 fd=2", g1[7:0], g2[7:0], fd_cnt - fd0);
    end
    TxBuffer = 32'hDEADCE11;
  endtask

  task automatic test_reset_midframe();
    logic [39:0] got;
    logic        bm;
    int          bd0, busy0;
    CPOL = 1'b0; CPHA = 1'b0; PCLK = 1'b0; COPI = 1'b1;
    repeat (8) @(negedge clk);
    CS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      PCLK = ~PCLK;
      repeat (H) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({CIPO, CIPO_OE, BUSY, BYTE_DONE, FRAME_DONE} !== 5'b0 ||
        RxBuffer !== 32'h0 || BYTE_COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_async: got flags=%b rx=%h cnt=%0d want 0",
               {CIPO, CIPO_OE, BUSY, BYTE_DONE, FRAME_DONE}, RxBuffer, BYTE_COUNT);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bd0 = bd_cnt; busy0 = busy_cnt;
    for (int k = 0; k < 16; k++) begin
      PCLK = ~PCLK;
      repeat (H) @(negedge clk);
    end
    vectors++;
    if (busy_cnt != busy0 || bd_cnt != bd0 || RxBuffer !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_ignore: got busy=%0d bd=%0d rx=%h want 0/0/0",
               busy_cnt - busy0, bd_cnt - bd0, RxBuffer);
    end
    CS_n = 1'b1;
    COPI = 1'b0;
    run_frame(1'b0, 1'b0, 8, 40'h5A, 1'b0, got, bm);
    $display("rst_midframe: rx=%h cipo=%h", RxBuffer, got[7:0]);
    vectors++;
    if (RxBuffer !== 32'h0000005A || got[7:0] !== 8'hDE) begin
      miscompares++;
      $display("FAIL rst_newframe: got rx=%h cipo=%h want 0000005a/de", RxBuffer, got[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_modes();
    test_overflow();
    test_abort();
    test_cpol_change();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of flip-flops in each input synchronizer (min 2).
REQ-002 Parameter MAX_BYTES, 4, depth of transmit/receive byte buffers (1..4).
REQ-003 clk  input  1  system clock; all logic is synchronous to clk, except asynchronous reset.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 CPOL  input  1  SPI clock idle level; sampled at frame start.
REQ-006 CPHA  input  1  SPI clock phase; 0 = sample on leading edge, 1 = sample on trailing edge; sampled at frame start.
REQ-007 CS_n  input  1  chip select from controller, active low, asynchronous to clk.
REQ-008 PCLK  input  1  serial clock from controller, asynchronous to clk, frequency <= clk/8.
REQ-009 COPI  input  1  controller-out/peripheral-in serial data, MSB first.
REQ-010 TxBuffer  input  MAX_BYTES x 8  reply data; byte [MAX_BYTES-1] is sent first, MSB first.
REQ-011 CIPO  output  1  controller-in/peripheral-out serial data.
REQ-012 CIPO_OE  output  1  CIPO output enable, 1 only while the frame is active.
REQ-013 RxBuffer  output  MAX_BYTES x 8  received bytes; [0] = most recent complete byte.
REQ-014 BYTE_DONE  output  1  one-clk pulse per completed received byte.
REQ-015 FRAME_DONE  output  1  one-clk pulse at the end of the frame.
REQ-016 BYTE_COUNT  output  3  completed bytes in the current/last frame, saturating at MAX_BYTES.
REQ-017 BUSY  output  1  high while the state is ACTIVE.

Function
REQ-018 CS_n, PCLK and COPI each pass through a SYNC_STAGES synchronizer; PCLK and CS_n edges are detected from the last two synchronized samples.
REQ-019 States: IDLE, ACTIVE, DONE.
- IDLE->ACTIVE on synchronized CS_n falling edge.
- ACTIVE->DONE on synchronized CS_n rising edge.
- DONE->IDLE unconditionally after 1 clk.
REQ-020 On the IDLE->ACTIVE transition, the block latches CPOL/CPHA into mode registers, loads TxBuffer into the tx shift register, clears BYTE_COUNT and the bit counter, and holds RxBuffer unchanged.
REQ-021 Leading edge = synchronized PCLK leaving level CPOL; trailing edge = PCLK returning to CPOL; classification uses the latched mode.
REQ-022 Sampling edge = leading edge if CPHA=0, trailing edge if CPHA=1; on each sampling edge the synchronized COPI shifts into the rx shift register LSB and the 3-bit bit counter increments (wraps 7->0).
REQ-023 CPHA=0: the first bit (TxBuffer[MAX_BYTES-1][7]) is on CIPO in the clk cycle after entering ACTIVE; subsequent bits update on each trailing edge.
REQ-024 CPHA=1: each bit, including the first, updates on the leading edge.
REQ-025 On the 8th sampling edge of a byte, in the following clk:
- RxBuffer shifts up one byte and the new byte is written to RxBuffer[0]; RxBuffer[MAX_BYTES-1] is discarded.
- BYTE_DONE pulses.
- BYTE_COUNT increments, saturating at MAX_BYTES.
REQ-026 After MAX_BYTES bytes have been sent, CIPO drives 0 for the remainder of the frame; reception continues per REQ-025.
REQ-027 CS_n rising edge mid-byte: partial rx bits are discarded; RxBuffer and BYTE_COUNT keep the last completed values; FRAME_DONE still pulses.
REQ-028 FRAME_DONE pulses in DONE; CIPO_OE=0 and CIPO=0 in IDLE and DONE.
REQ-029 CPOL/CPHA changes during ACTIVE are ignored until the next frame.
REQ-030 Latency: BYTE_DONE is asserted SYNC_STAGES+2 clk after the 8th sampling PCLK edge at the pin.
REQ-031 A PCLK edge coinciding with the CS_n rising edge is ignored, because the CS_n edge takes priority.

Reset
REQ-032 rst=1 asynchronously forces:
- state IDLE;
- all synchronizers to their idle values (CS_n=1, PCLK=0, COPI=0);
- shift registers, RxBuffer, BYTE_COUNT, CIPO, CIPO_OE, BUSY, BYTE_DONE and FRAME_DONE to 0.
REQ-033 If rst deasserts while CS_n is low, the block stays IDLE until a new CS_n falling edge; no partial frame is accepted.

Verification
REQ-034 Mode 0, TxBuffer=32'hDEADCE11, 1-byte frame with COPI=8'hA5 -> CIPO=8'hDE, RxBuffer[0]=8'hA5, BYTE_COUNT=1, one BYTE_DONE, one FRAME_DONE.
REQ-035 Each mode 0-3, 4-byte frame with COPI=32'h12345678 -> RxBuffer={12,34,56,78} ([3]..[0]), CIPO sequence DE AD CE 11, four BYTE_DONE pulses.
REQ-036 5-byte frame, COPI bytes 01..05 -> RxBuffer={02,03,04,05}, BYTE_COUNT=4, 5th CIPO byte 8'h00.
REQ-037 CS_n raised after 3 bits of byte 2 (byte 1 = 8'h3C) -> RxBuffer[0]=8'h3C, BYTE_COUNT=1, FRAME_DONE pulses, no 2nd BYTE_DONE.
REQ-038 rst pulsed mid-frame with CS_n held low -> all outputs 0 immediately; following PCLK edges ignored; next CS_n low frame of 8'h5A -> RxBuffer[0]=8'h5A.
REQ-039 CPOL toggled mid-frame in mode 1 -> received byte unchanged versus an undisturbed mode-1 frame.
